// File: rtl/cpu_pkg.sv
// Shared register-file write types for the WB/MD write-port arbiter.
package cpu_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rw;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [31:0] rw_onehot(input logic [REG_W-1:0] rw);
    return 32'b1 << rw;
  endfunction
endpackage

// File: rtl/wb_hold_fifo.sv
// Hold FIFO for MUL/DIV results waiting on the register-file write port.
// Entries can be killed in place by destination match; killed slots still occupy space until popped.
module wb_hold_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  wb_req_t                    i_push_req,
  input  logic                       i_pop,
  input  logic                       i_kill_en,
  input  logic [REG_W-1:0]           i_kill_rw,
  output wb_req_t                    o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [DEPTH-1:0]           o_valid_mask,
  output logic [DEPTH*REG_W-1:0]     o_rw_flat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t        r_mem [DEPTH];
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;

  // Kill first, then pop and push; push always lands in an unoccupied slot,
  // so a same-cycle incoming entry is never hit by the kill.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill_en && r_mem[i].valid && (r_mem[i].rw == i_kill_rw))
          r_mem[i].valid <= 1'b0;
      end
      if (i_pop) begin
        r_mem[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_req;
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_comb begin
    o_valid_mask = '0;
    o_rw_flat    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_valid_mask[i]              = r_mem[i].valid;
      o_rw_flat[i*REG_W +: REG_W]  = r_mem[i].rw;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, MUL/DIV results bypass or wait in a hold FIFO.
// Raises Stall_Req when the FIFO head starves and kills buffered writes overwritten by WB (WAW).
module wb_port_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              WB_RegWr,
  input  logic [REG_W-1:0]  WB_Rw,
  input  logic [DATA_W-1:0] WB_Data,
  input  logic              MD_Valid,
  input  logic [REG_W-1:0]  MD_Rw,
  input  logic [DATA_W-1:0] MD_Data,
  output logic              MD_Ready,
  output logic              RF_We,
  output logic [REG_W-1:0]  RF_Rw,
  output logic [DATA_W-1:0] RF_Data,
  output logic [31:0]       Pend_Mask,
  output logic              Stall_Req
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  // MD handshake: a result transfers on any cycle with MD_Valid & MD_Ready;
  // MD_Ready depends only on registered occupancy, never on same-cycle traffic.
  logic                   w_wb_busy;
  logic                   w_empty;
  logic                   w_md_live;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_bypass;
  logic [CW-1:0]          w_count;
  wb_req_t                w_head;
  wb_req_t                w_push_req;
  logic [DEPTH-1:0]       w_valid_mask;
  logic [DEPTH*REG_W-1:0] w_rw_flat;

  logic [WW-1:0]          r_wait_cnt;
  logic                   r_stall_req;

  assign w_wb_busy  = WB_RegWr && (WB_Rw != '0);
  assign w_empty    = (w_count == '0);
  assign MD_Ready   = !reset && (w_count < CW'(DEPTH));
  assign w_md_live  = MD_Valid && MD_Ready && (MD_Rw != '0);
  assign w_pop      = !w_wb_busy && !w_empty;
  assign w_push     = w_md_live && (w_wb_busy || !w_empty);
  assign w_bypass   = w_md_live && !w_wb_busy && w_empty;
  assign w_push_req = '{valid: 1'b1, rw: MD_Rw, data: MD_Data};

  wb_hold_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk        (CLK),
    .i_rst        (reset),
    .i_push       (w_push),
    .i_push_req   (w_push_req),
    .i_pop        (w_pop),
    .i_kill_en    (w_wb_busy),
    .i_kill_rw    (WB_Rw),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_valid_mask (w_valid_mask),
    .o_rw_flat    (w_rw_flat)
  );

  // A killed head still pops, but its slot produces no write.
  always_comb begin
    RF_We   = 1'b0;
    RF_Rw   = '0;
    RF_Data = '0;
    if (!reset) begin
      if (w_wb_busy) begin
        RF_We   = 1'b1;
        RF_Rw   = WB_Rw;
        RF_Data = WB_Data;
      end else if (!w_empty) begin
        if (w_head.valid) begin
          RF_We   = 1'b1;
          RF_Rw   = w_head.rw;
          RF_Data = w_head.data;
        end
      end else if (w_bypass) begin
        RF_We   = 1'b1;
        RF_Rw   = MD_Rw;
        RF_Data = MD_Data;
      end
    end
  end

  always_comb begin
    Pend_Mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid_mask[i])
        Pend_Mask = Pend_Mask | rw_onehot(w_rw_flat[i*REG_W +: REG_W]);
    end
  end

  // Wait counter saturates at MAX_WAIT; the stall stays up until the head finally drains.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_wait_cnt  <= '0;
      r_stall_req <= 1'b0;
    end else if (w_pop) begin
      r_wait_cnt  <= '0;
      r_stall_req <= 1'b0;
    end else if (w_empty) begin
      r_wait_cnt  <= '0;
    end else if (r_wait_cnt < WW'(MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + WW'(1);
      if (r_wait_cnt == WW'(MAX_WAIT - 1))
        r_stall_req <= 1'b1;
    end
  end

  assign Stall_Req = r_stall_req;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        CLK;
  logic        reset;
  logic        WB_RegWr;
  logic [4:0]  WB_Rw;
  logic [31:0] WB_Data;
  logic        MD_Valid;
  logic [4:0]  MD_Rw;
  logic [31:0] MD_Data;
  logic        MD_Ready;
  logic        RF_We;
  logic [4:0]  RF_Rw;
  logic [31:0] RF_Data;
  logic [31:0] Pend_Mask;
  logic        Stall_Req;

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .WB_RegWr  (WB_RegWr),
    .WB_Rw     (WB_Rw),
    .WB_Data   (WB_Data),
    .MD_Valid  (MD_Valid),
    .MD_Rw     (MD_Rw),
    .MD_Data   (MD_Data),
    .MD_Ready  (MD_Ready),
    .RF_We     (RF_We),
    .RF_Rw     (RF_Rw),
    .RF_Data   (RF_Data),
    .Pend_Mask (Pend_Mask),
    .Stall_Req (Stall_Req)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference model: pending MD writes in arrival order, plus register-file images
  typedef struct {
    bit        v;
    bit [4:0]  rw;
    bit [31:0] d;
  } ent_t;

  ent_t      mq[$];
  int        m_wait;
  bit        m_stall;
  bit [31:0] m_rf[32];
  bit [31:0] o_rf[32];

  int n_checks;
  int n_errors;

  logic        s_we;
  logic [4:0]  s_rw;
  logic [31:0] s_data;
  logic [31:0] s_pend;
  logic        s_ready;
  logic        s_stall;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare combinational outputs against the model, then advance the model.
  task automatic step(input bit wr, input bit [4:0] rw, input bit [31:0] d,
                      input bit mv, input bit [4:0] mrw, input bit [31:0] md);
    bit        busy, acc, had, popped, e_we;
    bit [4:0]  e_rw;
    bit [31:0] e_d, e_pend;
    @(negedge CLK);
    WB_RegWr = wr;  WB_Rw = rw;  WB_Data = d;
    MD_Valid = mv;  MD_Rw = mrw; MD_Data = md;
    #2;
    busy = wr && (rw != 0);
    had  = (mq.size() > 0);
    acc  = mv && (mq.size() < DEPTH);
    e_pend = 0;
    foreach (mq[i]) if (mq[i].v) e_pend[mq[i].rw] = 1'b1;
    e_we = 0; e_rw = 0; e_d = 0;
    if (busy) begin
      e_we = 1; e_rw = rw; e_d = d;
    end else if (had) begin
      if (mq[0].v) begin e_we = 1; e_rw = mq[0].rw; e_d = mq[0].d; end
    end else if (acc && mrw != 0) begin
      e_we = 1; e_rw = mrw; e_d = md;
    end
    s_we = RF_We; s_rw = RF_Rw; s_data = RF_Data;
    s_pend = Pend_Mask; s_ready = MD_Ready; s_stall = Stall_Req;
    chk("rf_we",     {31'b0, s_we},    {31'b0, e_we});
    chk("rf_rw",     {27'b0, s_rw},    {27'b0, e_rw});
    chk("rf_data",   s_data,           e_d);
    chk("pend_mask", s_pend,           e_pend);
    chk("md_ready",  {31'b0, s_ready}, {31'b0, mq.size() < DEPTH});
    chk("stall_req", {31'b0, s_stall}, {31'b0, m_stall});
    if (s_we) o_rf[s_rw] = s_data;
    if (e_we) m_rf[e_rw] = e_d;
    @(posedge CLK);
    popped = !busy && had;
    if (busy) foreach (mq[i]) if (mq[i].rw == rw) mq[i].v = 0;
    if (popped) mq.delete(0);
    if (acc && mrw != 0 && (busy || had)) mq.push_back('{v: 1, rw: mrw, d: md});
    if (popped) begin
      m_wait = 0; m_stall = 0;
    end else if (!had) begin
      m_wait = 0;
    end else begin
      m_wait++;
      if (m_wait >= MAX_WAIT) m_stall = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1;
    WB_RegWr = 1'b1; WB_Rw = 5'd3; WB_Data = 32'h3333;
    MD_Valid = 1'b1; MD_Rw = 5'd6; MD_Data = 32'h6666;
    #2;
    chk("rst_rf_we",    {31'b0, RF_We},     32'd0);
    chk("rst_md_ready", {31'b0, MD_Ready},  32'd0);
    chk("rst_stall",    {31'b0, Stall_Req}, 32'd0);
    chk("rst_pend",     Pend_Mask,          32'd0);
    @(negedge CLK);
    reset = 1'b0;
    WB_RegWr = 1'b0; WB_Rw = 0; WB_Data = 0;
    MD_Valid = 1'b0; MD_Rw = 0; MD_Data = 0;
    mq.delete();
    m_wait = 0; m_stall = 0;
    #1;
    chk("post_rst_ready", {31'b0, MD_Ready}, 32'd1);
    chk("post_rst_pend",  Pend_Mask,         32'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    foreach (m_rf[i]) begin m_rf[i] = 0; o_rf[i] = 0; end
    reset = 1'b1;
    WB_RegWr = 0; WB_Rw = 0; WB_Data = 0;
    MD_Valid = 0; MD_Rw = 0; MD_Data = 0;
    m_wait = 0; m_stall = 0;

    do_reset();

    // MD bypass when idle and empty
    step(0, 0, 0, 1, 5, 32'hDEAD);
    chk("t2_we",   {31'b0, s_we},  32'd1);
    chk("t2_rw",   {27'b0, s_rw},  32'd5);
    chk("t2_data", s_data,         32'hDEAD);
    chk("t2_pend", s_pend,         32'd0);

    // two buffered results behind a busy WB, then FIFO-order drain
    step(1, 7, 32'hA7, 1, 8, 32'h88);
    step(1, 7, 32'hB7, 1, 9, 32'h99);
    step(1, 7, 32'hC7, 0, 0, 0);
    chk("t3_pend",  s_pend,           32'h300);
    chk("t3_ready", {31'b0, s_ready}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("t3_first_we", {31'b0, s_we}, 32'd1);
    chk("t3_first_rw", {27'b0, s_rw}, 32'd8);
    step(0, 0, 0, 0, 0, 0);
    chk("t3_second_rw",   {27'b0, s_rw}, 32'd9);
    chk("t3_second_data", s_data,        32'h99);

    // starvation raises the stall after MAX_WAIT blocked cycles
    step(1, 7, 32'h1, 1, 8, 32'h8888);
    repeat (MAX_WAIT) step(1, 7, $urandom, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t4_stall_set", {31'b0, s_stall}, 32'd1);
    chk("t4_drain_rw",  {27'b0, s_rw},    32'd8);
    step(0, 0, 0, 0, 0, 0);
    chk("t4_stall_clr", {31'b0, s_stall}, 32'd0);

    // WAW kill of a buffered entry
    step(1, 7, 32'h2, 1, 10, 32'h1111);
    step(1, 10, 32'h2222, 0, 0, 0);
    chk("t5_pend_before", s_pend, 32'h400);
    step(0, 0, 0, 0, 0, 0);
    chk("t5_pend_after", s_pend,        32'd0);
    chk("t5_killed_we",  {31'b0, s_we}, 32'd0);
    chk("t5_r10",        o_rf[10],      32'h2222);

    // $0 handling on both sides
    step(0, 0, 0, 1, 0, 32'hBAD0);
    chk("t6_md_r0_we",    {31'b0, s_we},    32'd0);
    chk("t6_md_r0_ready", {31'b0, s_ready}, 32'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("t6_after_pend",  s_pend,           32'd0);
    chk("t6_after_we",    {31'b0, s_we},    32'd0);
    step(1, 7, 32'h3, 1, 4, 32'h4444);
    step(1, 0, 32'hFFFF, 0, 0, 0);
    chk("t6_wb_r0_we",   {31'b0, s_we}, 32'd1);
    chk("t6_wb_r0_rw",   {27'b0, s_rw}, 32'd4);
    chk("t6_wb_r0_data", s_data,        32'h4444);

    // random traffic, honouring the hazard-unit bubble after Stall_Req
    for (int i = 0; i < 600; i++) begin
      bit wr;
      if (i == 300) do_reset();
      wr = m_stall ? 1'b0 : ($urandom_range(0, 99) < 65);
      step(wr, 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom);
    end

    for (int r = 0; r < 32; r++) chk($sformatf("rf_image_r%0d", r), o_rf[r], m_rf[r]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
